// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO bus controller.
// Device index width helper keeps NUM_DEV == 1 at a legal 1-bit width.
package mmio_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [31:0] MMIO_BASE_DEF = 32'hffff0000;
  localparam logic [31:0] ERR_DATA_DEF  = 32'hdeadbeef;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_region_match.sv
// Combinational MMIO address decode: region hit, mapped device window,
// device index and byte offset within the window.
module mmio_region_match
  import mmio_pkg::*;
#(
  parameter int          NUM_DEV   = 4,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          DEV_SPAN  = 16,
  parameter logic [31:0] MMIO_SIZE = 32'h00010000,
  localparam int         IW        = idx_w(NUM_DEV),
  localparam int         OW        = $clog2(DEV_SPAN)
) (
  input  logic [31:0]   addr_i,
  output logic          in_region_o,
  output logic          mapped_o,
  output logic [IW-1:0] idx_o,
  output logic [OW-1:0] offset_o
);

  localparam logic [31:0] REGION_END = MMIO_BASE + MMIO_SIZE;
  localparam logic [31:0] WIN_BYTES  = 32'(NUM_DEV * DEV_SPAN);

  logic [31:0] off;

  assign off = addr_i - MMIO_BASE;

  // A region end that wraps to 0 means "up to the top of the address space".
  assign in_region_o = (addr_i >= MMIO_BASE) &&
                       ((REGION_END == 32'd0) || (addr_i < REGION_END));
  assign mapped_o    = in_region_o && (off < WIN_BYTES) && (addr_i[1:0] == 2'b00);
  assign idx_o       = IW'(off >> OW);
  assign offset_o    = OW'(off);

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MEM-stage bus controller: memory passthrough plus stalled, one-hot
// device handshakes ending on dev_ready or timeout, with bus-error reporting.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int          NUM_DEV   = 4,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int          DEV_SPAN  = 16,
  parameter logic [31:0] MMIO_SIZE = 32'h00010000,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF,
  localparam int         IW        = idx_w(NUM_DEV),
  localparam int         OW        = $clog2(DEV_SPAN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [31:0]           addr,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  stall,
  output logic                  bus_err,
  output logic                  we_mem,
  input  logic [31:0]           mem_readdata,
  output logic [NUM_DEV-1:0]    dev_sel,
  output logic                  dev_we,
  output logic [OW-1:0]         dev_addr,
  output logic [31:0]           dev_wdata,
  input  logic [NUM_DEV*32-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]    dev_ready
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  state_e      state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          req, in_region, mapped;
  logic [IW-1:0] idx;
  logic [OW-1:0] off;
  logic [NUM_DEV-1:0][31:0] rd_arr;
  logic          sel_ready;
  logic [31:0]   sel_rdata;

  mmio_region_match #(
    .NUM_DEV  (NUM_DEV),
    .MMIO_BASE(MMIO_BASE),
    .DEV_SPAN (DEV_SPAN),
    .MMIO_SIZE(MMIO_SIZE)
  ) u_match (
    .addr_i     (addr),
    .in_region_o(in_region),
    .mapped_o   (mapped),
    .idx_o      (idx),
    .offset_o   (off)
  );

  assign req       = memread | memwrite;
  assign rd_arr    = dev_rdata;
  assign sel_ready = dev_ready[idx_q];
  assign sel_rdata = rd_arr[idx_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req && mapped) begin
          state_d = ACCESS;
          idx_d   = idx;
          off_d   = off;
          wdata_d = writedata;
          we_d    = memwrite;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ACCESS: begin
        // Ready is checked first so a same-cycle ready beats the timeout.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO)) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so a still-presented MMIO
  // request cannot re-raise stall before the pipeline is released.
  always_comb begin
    readdata = '0;
    stall    = 1'b0;
    bus_err  = 1'b0;
    we_mem   = 1'b0;
    dev_sel  = '0;
    dev_we   = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (!in_region) begin
            we_mem   = memwrite;
            readdata = mem_readdata;
          end else if (req && mapped) begin
            stall = 1'b1;
          end else if (req) begin
            bus_err  = 1'b1;
            readdata = ERR_DATA;
          end
        end
        ACCESS: begin
          stall   = 1'b1;
          dev_sel = NUM_DEV'(1) << idx_q;
          dev_we  = we_q;
        end
        DONE: begin
          readdata = rdata_q;
          bus_err  = err_q;
        end
        default: ;
      endcase
    end
  end

  assign dev_addr  = off_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_mmio_bus_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         memwrite, memread;
  logic [31:0]  addr, writedata, readdata, mem_readdata, dev_wdata;
  logic         stall, bus_err, we_mem, dev_we;
  logic [3:0]   dev_sel, dev_ready, dev_addr;
  logic [127:0] dev_rdata;

  typedef struct {
    string       name;
    logic        stall;
    logic        err;
    logic        we;
    logic [3:0]  sel;
    bit          care_dev;
    logic        dwe;
    logic [3:0]  daddr;
    logic [31:0] dwdata;
    bit          care_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  mmio_bus_ctrl #(.NUM_DEV(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .memwrite(memwrite), .memread(memread),
    .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
    .bus_err(bus_err), .we_mem(we_mem), .mem_readdata(mem_readdata),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string n, input logic s, er, w,
                              input logic [3:0] sl, input bit cd, input logic dw,
                              input logic [3:0] da, input logic [31:0] dwd,
                              input bit cr, input logic [31:0] r);
    exp_t x;
    x.name = n; x.stall = s; x.err = er; x.we = w; x.sel = sl;
    x.care_dev = cd; x.dwe = dw; x.daddr = da; x.dwdata = dwd;
    x.care_rd = cr; x.rd = r;
    return x;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      bit bad;
      e = q.pop_front();
      vectors++;
      bad = (stall !== e.stall) || (bus_err !== e.err) || (we_mem !== e.we) ||
            (dev_sel !== e.sel);
      if (e.care_dev)
        bad = bad || (dev_we !== e.dwe) || (dev_addr !== e.daddr) || (dev_wdata !== e.dwdata);
      if (e.care_rd) bad = bad || (readdata !== e.rd);
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got stall=%b err=%b we=%b sel=%b dwe=%b daddr=%h dwdata=%h rd=%h; want stall=%b err=%b we=%b sel=%b dwe=%b daddr=%h dwdata=%h rd=%h",
                 e.name, stall, bus_err, we_mem, dev_sel, dev_we, dev_addr, dev_wdata, readdata,
                 e.stall, e.err, e.we, e.sel, e.dwe, e.daddr, e.dwdata, e.rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic mw, mr, input logic [31:0] a, wd, mrd,
                     input logic [3:0] rdy);
    memwrite = mw; memread = mr; addr = a; writedata = wd;
    mem_readdata = mrd; dev_ready = rdy;
  endtask

  initial begin
    reset_n = 1'b0;
    dev_rdata = {32'hcafef00d, 32'h99aabbcc, 32'h11223344, 32'h55667788};
    drv(0, 0, 32'h0, 32'h0, 32'h0, 4'h0);
    tick();
    q.push_back(mk("reset", 0, 0, 0, 4'h0, 1, 0, 4'h0, 32'h0, 1, 32'h0));
    tick();
    reset_n = 1'b1;

    // Plain memory passthrough
    drv(1, 0, 32'h40, 32'h12345678, 32'h11112222, 4'h0);
    q.push_back(mk("mem_sw", 0, 0, 1, 4'h0, 0, 0, 0, 0, 1, 32'h11112222));
    tick();
    drv(0, 1, 32'h40, 32'h0, 32'h0badf00d, 4'h0);
    q.push_back(mk("mem_lw", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h0badf00d));
    tick();

    // Device write, ready 3 cycles after issue; other devices' ready ignored
    drv(1, 0, 32'hffff0014, 32'ha5a5a5a5, 32'h0, 4'h0);
    q.push_back(mk("dw_issue", 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tick();
    dev_ready = 4'b1101;
    q.push_back(mk("dw_acc1", 1, 0, 0, 4'b0010, 1, 1, 4'h4, 32'ha5a5a5a5, 0, 0));
    tick();
    dev_ready = 4'b0000;
    q.push_back(mk("dw_acc2", 1, 0, 0, 4'b0010, 1, 1, 4'h4, 32'ha5a5a5a5, 0, 0));
    tick();
    dev_ready = 4'b0010;
    q.push_back(mk("dw_acc3", 1, 0, 0, 4'b0010, 1, 1, 4'h4, 32'ha5a5a5a5, 0, 0));
    tick();
    dev_ready = 4'b0000;
    q.push_back(mk("dw_done", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h11223344));
    tick();

    // Device read, ready on first ACCESS cycle
    drv(0, 1, 32'hffff0030, 32'h0, 32'h0, 4'h0);
    q.push_back(mk("dr_issue", 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tick();
    dev_ready = 4'b1000;
    q.push_back(mk("dr_acc1", 1, 0, 0, 4'b1000, 1, 0, 4'h0, 32'h0, 0, 0));
    tick();
    dev_ready = 4'b0000;
    q.push_back(mk("dr_done", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 32'hcafef00d));
    tick();

    // Timeout: ACCESS lasts TIMEOUT+1 = 5 cycles
    drv(0, 1, 32'hffff0000, 32'h0, 32'h0, 4'h0);
    q.push_back(mk("to_issue", 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tick();
    for (int i = 0; i < 5; i++) begin
      q.push_back(mk($sformatf("to_acc%0d", i), 1, 0, 0, 4'b0001, 1, 0, 4'h0, 32'h0, 0, 0));
      tick();
    end
    q.push_back(mk("to_done", 0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 32'hdeadbeef));
    tick();
    drv(0, 0, 32'h0, 32'h0, 32'h0, 4'h0);
    q.push_back(mk("to_after", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tick();

    // Unmapped, misaligned, top-of-space, just-below-base
    drv(1, 0, 32'hffff0100, 32'h1, 32'h0, 4'hf);
    q.push_back(mk("unmapped", 0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 32'hdeadbeef));
    tick();
    drv(1, 0, 32'hffff0002, 32'h1, 32'h0, 4'h0);
    q.push_back(mk("misalign", 0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 32'hdeadbeef));
    tick();
    drv(0, 1, 32'hfffffffc, 32'h0, 32'h0, 4'h0);
    q.push_back(mk("top_addr", 0, 1, 0, 4'h0, 0, 0, 0, 0, 1, 32'hdeadbeef));
    tick();
    drv(1, 0, 32'hfffefffc, 32'h7, 32'h24682468, 4'h0);
    q.push_back(mk("below_base", 0, 0, 1, 4'h0, 0, 0, 0, 0, 1, 32'h24682468));
    tick();

    // Reset in the second ACCESS cycle
    drv(0, 1, 32'hffff0020, 32'h0, 32'h0, 4'h0);
    q.push_back(mk("rst_issue", 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tick();
    q.push_back(mk("rst_acc1", 1, 0, 0, 4'b0100, 1, 0, 4'h0, 32'h0, 0, 0));
    tick();
    reset_n = 1'b0;
    q.push_back(mk("rst_async", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tick();
    reset_n = 1'b1;
    drv(0, 1, 32'h80, 32'h0, 32'h13579bdf, 4'h0);
    q.push_back(mk("post_rst_lw", 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h13579bdf));
    tick();
    drv(0, 0, 32'h0, 32'h0, 32'h0, 4'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
